// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Single-outstanding word-wide data memory responder with a
//             valid/ready request channel, fixed per-type response latency,
//             address error detection and a backpressure-safe response.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter start values: the counter reaches zero in the last WAIT cycle,
    // so resp_valid rises exactly LAT edges after acceptance.
    localparam logic [3:0] c_rd_cnt_init = 4'(RD_LAT - 1);
    localparam logic [3:0] c_wr_cnt_init = 4'(WR_LAT - 1);
    localparam int         c_depth       = 2 ** ADDR_W;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic               r_write;
    logic               r_err;
    logic [ADDR_W-1:0]  r_idx;
    logic [31:0]        r_mem [0:c_depth-1];

    logic               w_accept;
    logic               w_addr_err;
    logic               w_cnt_done;

    // req_ready depends on state (and reset) only, never on req_valid
    assign req_ready  = (r_state == IDLE) && !reset;
    assign w_accept   = req_valid && req_ready;
    assign w_addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    assign w_cnt_done = (r_cnt == 4'd0);
    assign resp_valid = (r_state == RESP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_next = WAIT;
            WAIT:    if (w_cnt_done) w_state_next = RESP;
            RESP:    if (resp_ready) w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    // Request capture at acceptance and latency countdown in WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_cnt   <= req_write ? c_wr_cnt_init : c_rd_cnt_init;
            r_write <= req_write;
            r_err   <= w_addr_err;
            r_idx   <= req_addr[ADDR_W+1:2];
        end else if ((r_state == WAIT) && !w_cnt_done) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Response payload loads on WAIT->RESP and then holds through backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if ((r_state == WAIT) && w_cnt_done) begin
            resp_err   <= r_err;
            resp_rdata <= (r_write || r_err) ? 32'd0 : r_mem[r_idx];
        end
    end

    // Storage array: stores commit at acceptance; contents survive reset
    always_ff @(posedge clk) begin
        if (w_accept && req_write && !w_addr_err) begin
            r_mem[req_addr[ADDR_W+1:2]] <= req_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Self-checking bench for dmem_responder; a default-latency
//             instance covers store/load, backpressure, errors and reset,
//             a unit-latency instance covers back-to-back traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        f_req_valid, f_req_ready, f_req_write;
    logic [31:0] f_req_addr, f_req_wdata;
    logic        f_resp_valid, f_resp_ready, f_resp_err;
    logic [31:0] f_resp_rdata;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    logic [31:0] model [int];

    dmem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .RD_LAT(1), .WR_LAT(1)) dut_fast (
        .clk(clk), .reset(reset),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .resp_valid(f_resp_valid), .resp_ready(f_resp_ready),
        .resp_rdata(f_resp_rdata), .resp_err(f_resp_err)
    );

    always #5 clk = ~clk;

    // Edge counter used to measure acceptance/handshake spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Global time bound
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
    endfunction

    // Drive one request on the main instance, push the expectation, and
    // return one step after the acceptance edge with the fields scrambled.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output bit ok);
        exp_t e;
        int   idx;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        e.err   = addr_err(a);
        e.lat   = w ? WR_LAT : RD_LAT;
        e.rdata = 32'd0;
        idx     = int'(a[ADDR_W+1:2]);
        if (!e.err) begin
            if (w) model[idx] = d;
            else if (model.exists(idx)) e.rdata = model[idx];
        end
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
    endtask

    // Count edges from acceptance until resp_valid is seen (bounded)
    task automatic wait_resp(output int lat, output bit ok);
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        f_req_valid = 1'b0; f_req_write = 1'b0; f_req_addr = '0; f_req_wdata = '0;
        f_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_vec++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_vec++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", resp_err); end
        reset = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_store_load();
        logic        tw [2] = '{1'b1, 1'b0};
        logic [31:0] ta [2] = '{32'h10, 32'h10};
        logic [31:0] td [2] = '{32'hDEADBEEF, 32'h0};
        exp_t e;
        int   lat;
        bit   ok;
        resp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            send(tw[t], ta[t], td[t], ok);
            n_vec++; if (!ok) begin n_fail++; $display("FAIL sl_accept[%0d]: got timeout want accept", t); end
            wait_resp(lat, ok);
            e = sb_q.pop_front();
            n_vec++; if (!ok) begin n_fail++; $display("FAIL sl_resp[%0d]: got timeout want resp_valid", t); end
            n_vec++; if (lat != e.lat) begin n_fail++; $display("FAIL sl_lat[%0d]: got %0d want %0d", t, lat, e.lat); end
            n_vec++; if (resp_rdata !== e.rdata) begin n_fail++; $display("FAIL sl_rdata[%0d]: got %h want %h", t, resp_rdata, e.rdata); end
            n_vec++; if (resp_err !== e.err) begin n_fail++; $display("FAIL sl_err[%0d]: got %b want %b", t, resp_err, e.err); end
            @(posedge clk); #1;
            n_vec++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL sl_drop[%0d]: got %b want 0", t, resp_valid); end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        bit   ok;
        resp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL bp_accept: got timeout want accept"); end
        wait_resp(lat, ok);
        e = sb_q.pop_front();
        n_vec++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL bp_lat: got %0d (ok=%0d) want %0d", lat, ok, e.lat); end
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                         c, resp_valid, resp_rdata, resp_err, req_ready, e.rdata, e.err);
            end
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready); end
    endtask

    task automatic test_errors();
        logic        tw [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] ta [3] = '{32'h12, 32'h10, 32'h400};
        logic [31:0] td [3] = '{32'h1, 32'h0, 32'h0};
        exp_t e;
        int   lat;
        bit   ok;
        resp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            send(tw[t], ta[t], td[t], ok);
            n_vec++; if (!ok) begin n_fail++; $display("FAIL er_accept[%0d]: got timeout want accept", t); end
            wait_resp(lat, ok);
            e = sb_q.pop_front();
            n_vec++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL er_lat[%0d]: got %0d (ok=%0d) want %0d", t, lat, ok, e.lat); end
            n_vec++; if (resp_rdata !== e.rdata) begin n_fail++; $display("FAIL er_rdata[%0d]: got %h want %h", t, resp_rdata, e.rdata); end
            n_vec++; if (resp_err !== e.err) begin n_fail++; $display("FAIL er_err[%0d]: got %b want %b", t, resp_err, e.err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_load();
        exp_t e;
        int   lat;
        bit   ok;
        bit   seen;
        resp_ready = 1'b1;
        send(1'b0, 32'h10, 32'h0, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL rm_accept: got timeout want accept"); end
        sb_q.delete();
        reset = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_reset: got %b want 0", req_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b want 1", req_ready); end
        n_vec++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL rm_rdata_cleared: got %h want 0", resp_rdata); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++; if (seen) begin n_fail++; $display("FAIL rm_no_resp: got resp_valid=1 want 0"); end
        send(1'b0, 32'h10, 32'h0, ok);
        wait_resp(lat, ok);
        e = sb_q.pop_front();
        n_vec++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL rm_reload_lat: got %0d (ok=%0d) want %0d", lat, ok, e.lat); end
        n_vec++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rm_retained: got %h want deadbeef", resp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        logic [31:0] want;
        int          prev_hs = -1;
        int          lat;
        bit          ok;
        f_resp_ready = 1'b1;
        f_req_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data        = 32'hC0DE0000 | 32'(i);
            f_req_write = (i % 2 == 0);
            f_req_addr  = 32'((i / 2) * 4);
            f_req_wdata = data;
            want        = f_req_write ? 32'd0 : (32'hC0DE0000 | 32'(i - 1));
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (f_req_ready) begin ok = 1'b1; break; end
                @(posedge clk); #1;
            end
            n_vec++; if (!ok) begin n_fail++; $display("FAIL bb_accept[%0d]: got timeout want accept", i); end
            if (prev_hs >= 0) begin
                n_vec++; if (cyc != prev_hs) begin n_fail++; $display("FAIL bb_gap[%0d]: got %0d edges want 1", i, cyc + 1 - prev_hs); end
            end
            @(posedge clk); #1;
            lat = 0; ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (f_resp_valid) begin ok = 1'b1; break; end
                @(posedge clk); #1;
                lat++;
            end
            n_vec++; if (!ok || lat != 1) begin n_fail++; $display("FAIL bb_lat[%0d]: got %0d (ok=%0d) want 1", i, lat, ok); end
            n_vec++; if (f_resp_rdata !== want || f_resp_err !== 1'b0) begin n_fail++; $display("FAIL bb_data[%0d]: got %h err=%b want %h err=0", i, f_resp_rdata, f_resp_err, want); end
            n_vec++; if (f_req_ready !== 1'b0) begin n_fail++; $display("FAIL bb_ready_in_resp[%0d]: got %b want 0", i, f_req_ready); end
            @(posedge clk); #1;
            prev_hs = cyc;
        end
        f_req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_errors();
        test_reset_mid_load();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
